// File: rtl/gf_mult_arbiter_pkg.sv
// Shared constants and FSM encoding for the GF(2^m) multiplier arbiter.
package gf_pkg;

  // Field degree: operands and products are GF(2^163) elements.
  localparam int GF_M = 163;

  // Default watchdog limit, in cycles of mul_start, before an operation is aborted.
  localparam int GF_TIMEOUT = 200;

  // Controller states; the encoding is fixed so that IDLE is the all-zero reset value.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/gf_mult_arbiter_if.sv
// Requester, response and multiplier buses of the GF multiplier arbiter.
interface gf_mult_arbiter_if
  import gf_pkg::*;
#(
  parameter int M     = GF_M,
  parameter int N_REQ = 4
);
  // Requester side
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*M-1:0] req_a;
  logic [N_REQ*M-1:0] req_b;

  // Response side
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [M-1:0]       rsp_data;
  logic               rsp_err;

  // Shared multiplier side
  logic [M-1:0]       mul_a;
  logic [M-1:0]       mul_b;
  logic               mul_start;
  logic [M-1:0]       mul_z;
  logic               mul_done;

  // Status
  logic               busy;

  // The arbiter itself
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_z, mul_done,
    output req_ready, rsp_valid, rsp_data, rsp_err, mul_a, mul_b, mul_start, busy
  );

  // Requesters and the multiplier, seen from outside the arbiter
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_z, mul_done,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mul_a, mul_b, mul_start, busy
  );

endinterface

// File: rtl/gf_mult_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first active request after last_grant.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx
);

  int               w_k;
  logic [IDX_W-1:0] w_k_idx;
  logic             w_found;

  // Scan from last_grant+1 wrapping around; the first hit wins.
  always_comb begin
    // NOTE: every variable gets a default before the loop, otherwise paths
    // that never hit a request would hold the old value and infer a latch.
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    w_k_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_k     = (int'(i_last_grant) + i) % N_REQ;
      w_k_idx = IDX_W'(w_k);
      if (!w_found && i_req[w_k_idx]) begin
        w_found = 1'b1;
        o_grant = N_REQ'(1) << w_k_idx;
        o_idx   = w_k_idx;
      end
    end
  end

endmodule

// File: rtl/gf_mult_arbiter.sv
// Arbitrates N_REQ requesters onto one shared GF(2^m) multiplier with a watchdog.
module gf_mult_arbiter
  import gf_pkg::*;
#(
  parameter int M       = GF_M,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = GF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  gf_mult_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t           r_state;
  state_t           w_next;

  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] r_owner;
  logic [M-1:0]     r_op_a;
  logic [M-1:0]     r_op_b;
  logic [M-1:0]     r_result;
  logic             r_err;
  logic [WD_W-1:0]  r_wdog;

  logic [N_REQ-1:0] w_win_onehot;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_any;
  logic             w_timeout;
  logic             w_rsp_hs;
  logic [M-1:0]     w_a_arr [N_REQ];
  logic [M-1:0]     w_b_arr [N_REQ];

  // Unpack the flat operand buses into per-requester slices.
  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign w_a_arr[g] = bus.req_a[g*M +: M];
    assign w_b_arr[g] = bus.req_b[g*M +: M];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_win_onehot),
    .o_idx        (w_win_idx)
  );

  assign w_any     = |w_win_onehot;
  // Fires on the TIMEOUT-th RUN cycle, so RUN lasts at most TIMEOUT cycles.
  assign w_timeout = (r_wdog >= WD_W'(TIMEOUT - 1));
  // Only the owner's rsp_ready bit can complete the response.
  assign w_rsp_hs  = bus.rsp_ready[r_owner];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = GRANT;
      GRANT:   w_next = RUN;
      RUN:     if (bus.mul_done || w_timeout) w_next = DRAIN;
      DRAIN:   w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobe outputs decoded from state; each lives in a distinct state.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.mul_start = 1'b0;
    case (r_state)
      GRANT:   bus.req_ready[r_owner] = 1'b1;
      RUN:     bus.mul_start          = 1'b1;
      RESP:    bus.rsp_valid[r_owner] = 1'b1;
      default: ;
    endcase
  end

  assign bus.mul_a    = r_op_a;
  assign bus.mul_b    = r_op_b;
  assign bus.rsp_data = r_result;
  assign bus.rsp_err  = r_err;
  assign bus.busy     = (r_state != IDLE);

  // Datapath: operand/owner capture on the winning edge, watchdog, result, round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= IDX_W'(N_REQ - 1);
      r_owner      <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_wdog       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wdog <= '0;
          // Operands are captured as GRANT is entered so mul_a/mul_b are already stable in GRANT.
          if (w_any) begin
            r_owner <= w_win_idx;
            r_op_a  <= w_a_arr[w_win_idx];
            r_op_b  <= w_b_arr[w_win_idx];
          end
        end
        GRANT: r_wdog <= '0;
        RUN: begin
          if (r_wdog != WD_W'(TIMEOUT)) r_wdog <= r_wdog + 1'b1;
          // A completion in the timeout cycle still delivers its product.
          if (bus.mul_done) begin
            r_result <= bus.mul_z;
            r_err    <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end
        end
        RESP: if (w_rsp_hs) r_last_grant <= r_owner;
        default: ;
      endcase
    end
  end

endmodule
